// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder register block.
//   state_t     : frame FSM states
//   spi_mode_t  : latched clock polarity/phase for the current frame
//   ADDR_W      : width of the register address carried in the command byte
//   CMD_RW_BIT  : command byte bit that selects write (1) or read (0)
//   STATUS_ADDR : address of the optional read-only status register
package spi_pkg;

    localparam int ADDR_W     = 7;
    localparam int CMD_RW_BIT = 7;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_slave_regs_if.sv
// SPI pin bundle between the link master and the register responder.
//   sclk : serial clock, driven by master
//   ssn  : active-low select, driven by master
//   mosi : master-out data
//   miso : slave-out data
interface spi_slave_regs_if;

    logic sclk;
    logic ssn;
    logic mosi;
    logic miso;

    modport master (
        output sclk,
        output ssn,
        output mosi,
        input  miso
    );

    modport slave (
        input  sclk,
        input  ssn,
        input  mosi,
        output miso
    );

endinterface

// File: rtl/spi_edge_sync.sv
// Synchronizer for an asynchronous pin plus single-cycle edge pulses.
//   clk  : system clock
//   d    : asynchronous input pin
//   rise : one-cycle pulse on a synchronized 0->1 transition
//   fall : one-cycle pulse on a synchronized 1->0 transition
// The flops carry no reset: after a mid-frame reset the chain keeps the
// real pin level, so no phantom edge is produced when reset releases.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_p1;

    always_ff @(posedge clk) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        lvl_p1 <= sync_q[SYNC_STAGES-1];
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~lvl_p1;
    assign fall = ~sync_q[SYNC_STAGES-1] & lvl_p1;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI responder with a small 8-bit register file, oversampled in clk.
// Frame: command byte {rw, addr[6:0]} followed by data bytes; the address
// auto-increments (wrapping at NUM_REGS-1) after every data byte.
//   clk, reset : system clock, synchronous active-high reset
//   cpol, cpha : SPI mode, captured at each select falling edge
//   spi        : slave side of the sclk/ssn/mosi/miso bundle
//   regs       : flattened register file, reg i at [8i+7:8i]
//   wr_pulse   : one-cycle strobe when a register is written
//   wr_addr    : address of that write
//   busy       : high while a frame is in progress
// Build option SPI_SLAVE_REGS_STATUS_EN adds a read-only status register
// at 0x7F: {sticky overrun, completed write count mod 128}.
module spi_slave_regs
    import spi_pkg::*;
#(
    parameter int NUM_REGS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpol,
    input  logic                  cpha,
    spi_slave_regs_if.slave       spi,
    output logic [NUM_REGS*8-1:0] regs,
    output logic                  wr_pulse,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic                  busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            state, state_next;
    spi_mode_t         mode_q;
    logic [2:0]        bit_cnt;
    logic [6:0]        rx_sr;
    logic [7:0]        rx_byte;
    logic [7:0]        tx_sr;
    logic              miso_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        reg_file [NUM_REGS];

    logic sclk_rise, sclk_fall, ssn_rise, ssn_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_s;
    logic lead_edge, trail_edge;
    logic sample_evt, shift_evt, frame_start, frame_end;
    logic load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_byte;

`ifdef SPI_SLAVE_REGS_STATUS_EN
    logic       overrun_q;
    logic [6:0] wr_count_q;
`endif

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a <= LAST_ADDR;
    endfunction

    // Out-of-range addresses do not advance.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (a > LAST_ADDR) return a;
        if (a == LAST_ADDR) return '0;
        return a + ADDR_W'(1);
    endfunction

    function automatic logic [7:0] read_byte(input logic [ADDR_W-1:0] a);
        logic [7:0] val;
        val = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == ADDR_W'(i)) val = reg_file[i];
        end
`ifdef SPI_SLAVE_REGS_STATUS_EN
        if (a == STATUS_ADDR) val = {overrun_q, wr_count_q};
`endif
        return val;
    endfunction

    // Input synchronization: mosi uses the same depth as sclk so the data
    // bit seen with a sclk edge pulse is the one present at that pin edge.
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (clk),
        .d    (spi.sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ssn_sync (
        .clk  (clk),
        .d    (spi.ssn),
        .rise (ssn_rise),
        .fall (ssn_fall)
    );

    always_ff @(posedge clk) begin
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
    end

    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign rx_byte = {rx_sr, mosi_s};

    assign lead_edge  = mode_q.cpol ? sclk_fall : sclk_rise;
    assign trail_edge = mode_q.cpol ? sclk_rise : sclk_fall;

    // Frame FSM. sclk edges are only decoded outside IDLE, i.e. after a
    // synchronized select falling edge, so edges with ssn high are ignored.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        sample_evt  = 1'b0;
        shift_evt   = 1'b0;
        if (ssn_fall) begin
            state_next  = CMD;
            frame_start = 1'b1;
        end else if (ssn_rise) begin
            state_next = IDLE;
            frame_end  = (state != IDLE);
        end else if (state != IDLE) begin
            sample_evt = mode_q.cpha ? trail_edge : lead_edge;
            shift_evt  = mode_q.cpha ? lead_edge : trail_edge;
            if (state == CMD && sample_evt && bit_cnt == 3'd7) state_next = DATA;
        end
    end

    // Byte to transmit next: the addressed register right after the
    // command, then the following register after each data byte.
    always_comb begin
        load_en   = (state == CMD) ? ~rx_byte[CMD_RW_BIT] : ~rw_q;
        load_addr = (state == CMD) ? rx_byte[ADDR_W-1:0] : next_addr(addr_q);
        load_byte = read_byte(load_addr);
    end

    // Serial datapath and register file
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= 8'h00;
            mode_q   <= '0;
            bit_cnt  <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            miso_q   <= 1'b0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
`ifdef SPI_SLAVE_REGS_STATUS_EN
            overrun_q  <= 1'b0;
            wr_count_q <= '0;
`endif
        end else begin
            wr_pulse <= 1'b0;
            if (frame_start) begin
                mode_q  <= '{cpol: cpol, cpha: cpha};
                bit_cnt <= '0;
                tx_sr   <= 8'h00;
                miso_q  <= 1'b0;
            end else if (frame_end) begin
`ifdef SPI_SLAVE_REGS_STATUS_EN
                if (bit_cnt != 3'd0) overrun_q <= 1'b1;
`endif
                bit_cnt <= '0;
                tx_sr   <= 8'h00;
                miso_q  <= 1'b0;
            end else if (state != IDLE) begin
                // With cpha=0 the shift edge right after a byte's last sample
                // is the byte boundary; the reload already presented bit 7.
                if (shift_evt && (mode_q.cpha || bit_cnt != 3'd0)) begin
                    miso_q <= tx_sr[7];
                    tx_sr  <= {tx_sr[6:0], 1'b0};
                end
                if (sample_evt) begin
                    rx_sr   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (state == CMD) begin
                            rw_q   <= rx_byte[CMD_RW_BIT];
                            addr_q <= rx_byte[ADDR_W-1:0];
                        end else begin
                            addr_q <= next_addr(addr_q);
                            if (rw_q && in_range(addr_q)) begin
                                for (int i = 0; i < NUM_REGS; i++) begin
                                    if (addr_q == ADDR_W'(i)) reg_file[i] <= rx_byte;
                                end
                                wr_pulse <= 1'b1;
                                wr_addr  <= addr_q;
`ifdef SPI_SLAVE_REGS_STATUS_EN
                                wr_count_q <= wr_count_q + 7'd1;
`endif
                            end
                        end
                        if (load_en) begin
                            if (mode_q.cpha) begin
                                tx_sr <= load_byte;
                            end else begin
                                miso_q <= load_byte[7];
                                tx_sr  <= {load_byte[6:0], 1'b0};
                            end
`ifdef SPI_SLAVE_REGS_STATUS_EN
                            if (load_addr == STATUS_ADDR) overrun_q <= 1'b0;
`endif
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs[g*8 +: 8] = reg_file[g];
    end

    assign spi.miso = miso_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: bit-banged SPI master in all four modes with
// scoreboards for expected MISO bytes and expected register writes.
module tb_spi_slave_regs;

    localparam int NUM_REGS    = 4;
    localparam int SYNC_STAGES = 2;
    localparam int H           = 6;   // sclk half period in clk cycles

    logic clk = 1'b0;
    logic reset, cpol, cpha;
    logic [NUM_REGS*8-1:0] regs;
    logic       wr_pulse;
    logic [6:0] wr_addr;
    logic       busy;

    always #5 clk = ~clk;

    spi_slave_regs_if spi_bus ();

    spi_slave_regs #(
        .NUM_REGS    (NUM_REGS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpol     (cpol),
        .cpha     (cpha),
        .spi      (spi_bus),
        .regs     (regs),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .busy     (busy)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0]  model_regs [NUM_REGS];
    logic [6:0]  model_wcount;
    logic        model_ovr;
    logic [7:0]  tx_bytes [$];
    logic [7:0]  exp_q [$];
    logic [14:0] wr_q [$];
    logic [14:0] mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_flat();
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < NUM_REGS; i++) f[i*8 +: 8] = model_regs[i];
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input int a, input logic [7:0] d);
        if (a < NUM_REGS) begin
            wr_q.push_back({7'(a), d});
            model_regs[a] = d;
            model_wcount  = model_wcount + 7'd1;
        end
    endtask

    task automatic ssn_low(input logic cp, input logic ch);
        cpol         = cp;
        cpha         = ch;
        spi_bus.sclk = cp;
        spi_bus.mosi = 1'b0;
        tick(4);
        spi_bus.ssn = 1'b0;
        tick(4);
        check("busy_on", 32'(busy), 32'd1);
    endtask

    task automatic ssn_high();
        tick(H);
        spi_bus.ssn = 1'b1;
        tick(4);
        check("busy_off", 32'(busy), 32'd0);
        check("miso_idle", 32'(spi_bus.miso), 32'd0);
        tick(4);
    endtask

    // Master samples miso at its sample edge and confirms the slave holds
    // it for two clocks beyond that edge.
    task automatic spi_bits(input logic cp, input logic ch, input int nbits, input bit chk);
        logic [7:0] rx;
        logic       m, b;
        int         unstable;
        rx = 8'h00;
        unstable = 0;
        for (int i = 0; i < nbits; i++) begin
            b = tx_bytes[i/8][7 - (i % 8)];
            if (!ch) begin
                spi_bus.mosi = b;
                tick(H);
                m = spi_bus.miso;
                spi_bus.sclk = ~cp;
                tick(2);
                if (spi_bus.miso !== m) unstable++;
                tick(H - 2);
                spi_bus.sclk = cp;
            end else begin
                spi_bus.sclk = ~cp;
                spi_bus.mosi = b;
                tick(H);
                m = spi_bus.miso;
                spi_bus.sclk = cp;
                tick(2);
                if (spi_bus.miso !== m) unstable++;
                tick(H - 2);
            end
            rx = {rx[6:0], m};
            if (chk && (i % 8) == 7) begin
                if (exp_q.size() == 0) check("miso_exp_queue", 32'(exp_q.size()), 32'd1);
                else check("miso_byte", 32'(rx), 32'(exp_q.pop_front()));
                check("miso_stable", 32'(unstable), 32'd0);
                unstable = 0;
            end
        end
    endtask

    task automatic do_frame(input logic cp, input logic ch, input bit chk);
        ssn_low(cp, ch);
        spi_bits(cp, ch, tx_bytes.size() * 8, chk);
        ssn_high();
    endtask

    // Write scoreboard: every wr_pulse must match the oldest expected write
    // and must last exactly one clock.
    always begin
        @(negedge clk);
        if (wr_pulse === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 32'(wr_pulse), 32'd0);
            end else begin
                mon_e = wr_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_e[14:8]));
                check("wr_data", 32'(regs[int'(mon_e[14:8])*8 +: 8]), 32'(mon_e[7:0]));
            end
            @(negedge clk);
            check("wr_pulse_len", 32'(wr_pulse), 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        cpol         = 1'b0;
        cpha         = 1'b0;
        spi_bus.sclk = 1'b0;
        spi_bus.ssn  = 1'b1;
        spi_bus.mosi = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
        model_wcount = '0;
        model_ovr    = 1'b0;
        tick(5);
        reset = 1'b0;
        tick(1);
        check("rst_regs", regs, 32'h0);
        check("rst_miso", 32'(spi_bus.miso), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);

        // Mode 0 single write
        tx_bytes = '{8'h81, 8'hA5};
        expect_write(1, 8'hA5);
        do_frame(1'b0, 1'b0, 1'b0);
        check("m0_write_regs", regs, 32'h0000_A500);

        // Mode 3 burst write with address wrap
        tx_bytes = '{8'h80, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        expect_write(0, 8'h11);
        expect_write(1, 8'h22);
        expect_write(2, 8'h33);
        expect_write(3, 8'h44);
        expect_write(0, 8'h55);
        do_frame(1'b1, 1'b1, 1'b0);
        check("m3_burst_regs", regs, 32'h4433_2255);
        check("m3_burst_model", regs, model_flat());

        // Preload regs[2], then burst reads in modes 1 and 2
        tx_bytes = '{8'h82, 8'h3C};
        expect_write(2, 8'h3C);
        do_frame(1'b0, 1'b0, 1'b0);
        tx_bytes = '{8'h02, 8'h00, 8'h00};
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h3C);
        exp_q.push_back(model_regs[3]);
        do_frame(1'b0, 1'b1, 1'b1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h3C);
        exp_q.push_back(model_regs[3]);
        do_frame(1'b1, 1'b0, 1'b1);
        check("read_regs_kept", regs, model_flat());

        // Out-of-range write and read
        tx_bytes = '{8'h90, 8'hAB};
        expect_write(16, 8'hAB);
        do_frame(1'b0, 1'b0, 1'b0);
        check("oor_write_regs", regs, model_flat());
        tx_bytes = '{8'h10, 8'h00};
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        do_frame(1'b0, 1'b0, 1'b1);

        // Frame ended after 5 data bits: nothing written
        ssn_low(1'b0, 1'b0);
        tx_bytes = '{8'h80, 8'hFF};
        spi_bits(1'b0, 1'b0, 13, 1'b0);
        ssn_high();
        model_ovr = 1'b1;
        check("partial_regs", regs, model_flat());
        tx_bytes = '{8'h80, 8'h01};
        expect_write(0, 8'h01);
        do_frame(1'b0, 1'b0, 1'b0);
        check("after_partial_regs", regs, model_flat());

`ifdef SPI_SLAVE_REGS_STATUS_EN
        tx_bytes = '{8'h7F, 8'h00};
        exp_q.push_back(8'h00);
        exp_q.push_back({model_ovr, model_wcount});
        do_frame(1'b0, 1'b0, 1'b1);
        model_ovr = 1'b0;
        exp_q.push_back(8'h00);
        exp_q.push_back({model_ovr, model_wcount});
        do_frame(1'b0, 1'b0, 1'b1);
`endif

        // Reset in the middle of a mode 0 read of regs[1]
        ssn_low(1'b0, 1'b0);
        tx_bytes = '{8'h01, 8'h00};
        spi_bits(1'b0, 1'b0, 10, 1'b0);
        tick(4);
        check("pre_reset_miso", 32'(spi_bus.miso), 32'(model_regs[1][5]));
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
        model_wcount = '0;
        model_ovr    = 1'b0;
        check("mid_reset_regs", regs, 32'h0);
        check("mid_reset_miso", 32'(spi_bus.miso), 32'd0);
        check("mid_reset_busy", 32'(busy), 32'd0);
        tx_bytes = '{8'hFF};
        spi_bits(1'b0, 1'b0, 6, 1'b0);
        tick(4);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_regs", regs, 32'h0);
        ssn_high();

        tx_bytes = '{8'h83, 8'h77};
        expect_write(3, 8'h77);
        do_frame(1'b0, 1'b0, 1'b0);
        check("new_frame_regs", regs, 32'h7700_0000);

`ifdef SPI_SLAVE_REGS_STATUS_EN
        tx_bytes = '{8'h7F, 8'h00};
        exp_q.push_back(8'h00);
        exp_q.push_back({model_ovr, model_wcount});
        do_frame(1'b1, 1'b1, 1'b1);
`endif

        tick(4);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        check("miso_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
